// File: rtl/top.sv
// -----------------------------------------------------------------------------
// top: 128-bit unsigned integer square root, asqrt = floor(sqrt(a)).
//
// Restoring digit-by-digit binary square root. Each cycle two radicand bits are
// shifted into a partial remainder and (root << 2) | 1 is trial-subtracted.
// One root bit is produced per cycle, MSB first, over 64 iterations.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   start request, accepted only while busy = 0
//   a[127:0]   unsigned radicand, sampled on the accept edge only
//   busy       high for exactly 64 cycles while iterating
//   out_valid  one-cycle pulse (DONE state) marking a new asqrt
//   asqrt      result register, updated only on completion
// -----------------------------------------------------------------------------
module top (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [127:0] a,
  output logic         busy,
  output logic         out_valid,
  output logic [63:0]  asqrt
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]   state_r;
  logic [1:0]   state_nxt_s;
  logic [5:0]   cnt_r;
  logic [127:0] rad_r;
  logic [65:0]  rem_r;
  logic [63:0]  root_r;
  logic         busy_r;
  logic         out_valid_r;
  logic [63:0]  asqrt_r;

  logic         accept_s;
  logic         last_s;
  logic [67:0]  shifted_s;
  logic [67:0]  trial_s;
  logic         root_bit_s;
  logic [65:0]  rem_nxt_s;
  logic [63:0]  root_nxt_s;

  // One square-root iteration on the current partial remainder and root.
  always_comb begin
    shifted_s  = {rem_r, rad_r[127:126]};
    trial_s    = {2'b00, root_r, 2'b01};
    root_bit_s = (shifted_s >= trial_s);
    // The true remainder never exceeds 2*root < 2^65, so 66 bits of the
    // difference (or of the unsubtracted value) are always exact.
    if (root_bit_s) begin
      rem_nxt_s = shifted_s[65:0] - trial_s[65:0];
    end else begin
      rem_nxt_s = shifted_s[65:0];
    end
    root_nxt_s = {root_r[62:0], root_bit_s};
  end

  // Accept and termination conditions, and next-state selection.
  always_comb begin
    accept_s    = in_valid && !busy_r;
    last_s      = (state_r == ST_CALC) && (cnt_r == 6'd63);
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_nxt_s = ST_CALC;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_CALC: begin
        if (last_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_CALC;
        end
      end
      ST_DONE: begin
        // A new request may be taken on the completion cycle.
        if (accept_s) begin
          state_nxt_s = ST_CALC;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      cnt_r       <= 6'd0;
      rad_r       <= 128'd0;
      rem_r       <= 66'd0;
      root_r      <= 64'd0;
      busy_r      <= 1'b0;
      out_valid_r <= 1'b0;
      asqrt_r     <= 64'd0;
    end else begin
      state_r     <= state_nxt_s;
      out_valid_r <= last_s;
      if (state_r == ST_CALC) begin
        rad_r  <= {rad_r[125:0], 2'b00};
        rem_r  <= rem_nxt_s;
        root_r <= root_nxt_s;
        cnt_r  <= cnt_r + 6'd1;
        if (last_s) begin
          busy_r  <= 1'b0;
          asqrt_r <= root_nxt_s;
        end else begin
          busy_r  <= 1'b1;
        end
      end else if (accept_s) begin
        rad_r  <= a;
        rem_r  <= 66'd0;
        root_r <= 64'd0;
        cnt_r  <= 6'd0;
        busy_r <= 1'b1;
      end else begin
        busy_r <= 1'b0;
      end
    end
  end

  assign busy      = busy_r;
  assign out_valid = out_valid_r;
  assign asqrt     = asqrt_r;

endmodule

// File: tb/tb_top.sv
module tb_top;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic [127:0] a;
  logic         busy;
  logic         out_valid;
  logic [63:0]  asqrt;

  int compared;
  int mismatched;

  top dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .busy      (busy),
    .out_valid (out_valid),
    .asqrt     (asqrt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Capture a with one in_valid pulse, then wait (bounded) for out_valid.
  // Checks latency, busy, that asqrt holds until completion, and the result.
  task automatic run(input string tag, input logic [127:0] val, input logic [63:0] exp);
    int n;
    logic [63:0] prev;
    logic held;
    logic busy_ok;
    prev     = asqrt;
    held     = 1'b1;
    busy_ok  = 1'b1;
    in_valid = 1'b1;
    a        = val;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a        = {$urandom, $urandom, $urandom, $urandom};
    n = 0;
    while (n < 100) begin
      @(posedge clk); #1;
      n++;
      if (out_valid) break;
      if (asqrt !== prev) held = 1'b0;
      if (busy !== 1'b1) busy_ok = 1'b0;
    end
    check({tag, " latency"}, 128'(n), 128'd64);
    check({tag, " hold"}, {127'd0, held}, 128'd1);
    check({tag, " busy"}, {127'd0, busy_ok}, 128'd1);
    check({tag, " busy_low"}, {127'd0, busy}, 128'd0);
    check({tag, " asqrt"}, {64'd0, asqrt}, {64'd0, exp});
    @(posedge clk); #1;
    check({tag, " pulse_end"}, {127'd0, out_valid}, 128'd0);
  endtask

  initial begin
    int n;
    int pulses;
    logic [127:0] r;
    logic [128:0] lo;
    logic [128:0] hi;
    logic [63:0]  q;
    logic         ok;

    compared   = 0;
    mismatched = 0;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    a          = 128'd0;
    #23;
    check("reset busy", {127'd0, busy}, 128'd0);
    check("reset out_valid", {127'd0, out_valid}, 128'd0);
    check("reset asqrt", {64'd0, asqrt}, 128'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    run("a0", 128'd0, 64'd0);
    run("a1", 128'd1, 64'd1);
    run("a2", 128'd2, 64'd1);
    run("a144", 128'd144, 64'd12);
    run("a65535", 128'hFFFF, 64'd255);
    run("a65536", 128'h10000, 64'd256);
    run("amax", {128{1'b1}}, 64'hFFFF_FFFF_FFFF_FFFF);
    run("a2p126", 128'd1 << 126, 64'h8000_0000_0000_0000);
    run("a1e6", 128'd1000000, 64'd1000);
    run("a99", 128'd99, 64'd9);

    // in_valid during busy is ignored; a request on the out_valid cycle is taken.
    in_valid = 1'b1;
    a        = 128'd49;
    @(posedge clk); #1;
    in_valid = 1'b0;
    pulses   = 0;
    n        = 0;
    while (n < 100) begin
      if (n == 10 || n == 40) begin
        in_valid = 1'b1;
        a        = 128'd100;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk); #1;
      n++;
      if (out_valid) begin
        pulses++;
        break;
      end
    end
    check("b2b first latency", 128'(n), 128'd64);
    check("b2b pulses", 128'(pulses), 128'd1);
    check("b2b first asqrt", {64'd0, asqrt}, 128'd7);
    in_valid = 1'b1;
    a        = 128'd100;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("b2b busy again", {127'd0, busy}, 128'd1);
    n = 0;
    while (n < 100) begin
      @(posedge clk); #1;
      n++;
      if (out_valid) break;
    end
    check("b2b second latency", 128'(n), 128'd64);
    check("b2b second asqrt", {64'd0, asqrt}, 128'd10);

    // Reset mid-computation aborts without a pulse.
    @(posedge clk); #1;
    in_valid = 1'b1;
    a        = 128'd1000000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    pulses   = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (out_valid) pulses++;
    end
    rst_n = 1'b0;
    #1;
    check("abort busy", {127'd0, busy}, 128'd0);
    check("abort asqrt", {64'd0, asqrt}, 128'd0);
    check("abort out_valid", {127'd0, out_valid}, 128'd0);
    check("abort no pulse", 128'(pulses), 128'd0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    run("restart", 128'd1000000, 64'd1000);

    // Random regression, checked against the defining inequality.
    ok = 1'b1;
    for (int i = 0; i < 600; i++) begin
      r = {$urandom, $urandom, $urandom, $urandom};
      case (i % 6)
        0: r = r >> $urandom_range(127, 0);
        1: r[15:0] = 16'hFFFF;
        2: r[15:0] = 16'h0000;
        3: r[47:16] = {4{r[23:16]}};
        4: r = r | {1'b1, 127'd0};
        default: r = r;
      endcase
      in_valid = 1'b1;
      a        = r;
      @(posedge clk); #1;
      in_valid = 1'b0;
      n = 0;
      while (n < 100) begin
        @(posedge clk); #1;
        n++;
        if (out_valid) break;
      end
      q  = asqrt;
      lo = 129'(q) * 129'(q);
      hi = (129'(q) + 129'd1) * (129'(q) + 129'd1);
      compared++;
      assert (n == 64 && lo <= {1'b0, r} && {1'b0, r} < hi) else begin
        mismatched++;
        ok = 1'b0;
        $error("FAIL random[%0d]: a=%0h observed asqrt=%0h cycles=%0d expected isqrt property at 64 cycles", i, r, q, n);
      end
      if (!ok) break;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
